// File: rtl/btb_update_unit.sv
// BTB update unit: checks resolved jalr targets against the front-end
// prediction, raises a registered redirect on a mispredict, and queues BTB
// corrections in a small circular FIFO. The FIFO drains one entry per cycle.
// Optional feature macro: BTB_UPDATE_COALESCE_EN. When it is defined, a new
// correction for a pc already in the queue overwrites that entry's target.

package riscv_pkg;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] addr_t;
endpackage

module btb_update_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int OFFSET     = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              debug_mode_i,
    input  logic              resolve_valid_i,
    output logic              resolve_ready_o,
    input  riscv_pkg::addr_t  resolve_pc_i,
    input  logic              resolve_pred_valid_i,
    input  riscv_pkg::addr_t  resolve_pred_target_i,
    input  riscv_pkg::addr_t  resolve_target_i,
    output logic              mispredict_o,
    output riscv_pkg::addr_t  redirect_pc_o,
    output logic              fb_valid_o,
    output riscv_pkg::addr_t  fb_branch_pc_o,
    output riscv_pkg::addr_t  fb_target_addr_o
);
    localparam int XLEN  = riscv_pkg::XLEN;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        riscv_pkg::addr_t pc;
        riscv_pkg::addr_t target;
    } entry_t;

    // Reject configurations the pointer arithmetic cannot handle.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || OFFSET >= XLEN) begin : g_bad_param
        $error("btb_update_unit: FIFO_DEPTH must be a power of two >= 2 and OFFSET < XLEN");
    end

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               full;
    logic               pop;
    logic               accept;
    logic               mispredict;
    logic               enqueue;
    logic               alloc;
    logic               coalesce_hit;
    logic [PTR_W-1:0]   hit_idx;

    assign full = (count == CNT_W'(FIFO_DEPTH));
    // The BTB never stalls, so any valid head entry leaves this cycle.
    assign pop  = (count != '0);

`ifdef BTB_UPDATE_COALESCE_EN
    // Find the youngest queued entry on the same pc line, skipping the head that is leaving.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no latch is inferred.
        coalesce_hit = 1'b0;
        hit_idx      = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(i) < count) && !(i == 0 && pop) &&
                (mem[head + PTR_W'(i)].pc[XLEN-1:OFFSET] == resolve_pc_i[XLEN-1:OFFSET])) begin
                coalesce_hit = 1'b1;
                hit_idx      = head + PTR_W'(i);
            end
        end
    end

    assign resolve_ready_o = !full || coalesce_hit;
`else
    assign coalesce_hit    = 1'b0;
    assign hit_idx         = '0;
    assign resolve_ready_o = !full;
`endif

    assign accept     = resolve_valid_i && resolve_ready_o && !flush_i;
    assign mispredict = accept && (!resolve_pred_valid_i ||
                                   (resolve_pred_target_i != resolve_target_i));
    // Debug mode still redirects fetch but must not train the BTB.
    assign enqueue    = mispredict && !debug_mode_i;
    assign alloc      = enqueue && !coalesce_hit;

    // Queue pointers, count and the registered redirect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
        end else if (flush_i) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            mispredict_o <= 1'b0;
        end else begin
            mispredict_o <= mispredict;
            if (mispredict) begin
                redirect_pc_o <= resolve_target_i;
            end
            if (alloc) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    // Entry storage; a flush only resets the pointers, stale data is never read as valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: storage is reset so the empty-queue BTB port reads a defined zero after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush_i) begin
            if (alloc) begin
                mem[tail] <= '{pc: resolve_pc_i, target: resolve_target_i};
            end else if (enqueue) begin
                mem[hit_idx].target <= resolve_target_i;
            end
        end
    end

    assign fb_valid_o       = pop;
    assign fb_branch_pc_o   = mem[head].pc;
    assign fb_target_addr_o = mem[head].target;

endmodule

// File: tb/tb_btb_update_unit.sv
// Self-checking bench for btb_update_unit: directed scenarios plus randomized
// traffic, each cycle compared against a queue-based reference model.
module tb_btb_update_unit;
    import riscv_pkg::*;

    localparam int DEPTH  = 4;
    localparam int OFFSET = 2;

    typedef struct {
        addr_t pc;
        addr_t target;
    } ent_t;

    logic  clk_i = 1'b0;
    logic  rst_ni = 1'b1;
    logic  flush_i = 1'b0;
    logic  debug_mode_i = 1'b0;
    logic  resolve_valid_i = 1'b0;
    logic  resolve_ready_o;
    addr_t resolve_pc_i = '0;
    logic  resolve_pred_valid_i = 1'b0;
    addr_t resolve_pred_target_i = '0;
    addr_t resolve_target_i = '0;
    logic  mispredict_o;
    addr_t redirect_pc_o;
    logic  fb_valid_o;
    addr_t fb_branch_pc_o;
    addr_t fb_target_addr_o;

    btb_update_unit #(.FIFO_DEPTH(DEPTH), .OFFSET(OFFSET)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .debug_mode_i          (debug_mode_i),
        .resolve_valid_i       (resolve_valid_i),
        .resolve_ready_o       (resolve_ready_o),
        .resolve_pc_i          (resolve_pc_i),
        .resolve_pred_valid_i  (resolve_pred_valid_i),
        .resolve_pred_target_i (resolve_pred_target_i),
        .resolve_target_i      (resolve_target_i),
        .mispredict_o          (mispredict_o),
        .redirect_pc_o         (redirect_pc_o),
        .fb_valid_o            (fb_valid_o),
        .fb_branch_pc_o        (fb_branch_pc_o),
        .fb_target_addr_o      (fb_target_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int    compared   = 0;
    int    mismatched = 0;

    // Reference model: pending corrections in order, plus the expected redirect.
    ent_t  q[$];
    bit    exp_mis   = 1'b0;
    addr_t exp_redir = '0;

    // One clock of stimulus; the model advances by the rules and outputs are compared after the edge.
    task automatic cycle(input bit v, input addr_t pc, input bit pv, input addr_t pt,
                         input addr_t tgt, input bit fl, input bit dbg);
        bit exp_ready;
        bit acc;
        bit mis;
        int hit;
        int lo;
        @(negedge clk_i);
        resolve_valid_i       = v;
        resolve_pc_i          = pc;
        resolve_pred_valid_i  = pv;
        resolve_pred_target_i = pt;
        resolve_target_i      = tgt;
        flush_i               = fl;
        debug_mode_i          = dbg;
        #1;
        hit = -1;
`ifdef BTB_UPDATE_COALESCE_EN
        lo = (q.size() != 0) ? 1 : 0;
        for (int i = q.size() - 1; i >= lo; i--) begin
            if (hit < 0 && (q[i].pc >> OFFSET) == (pc >> OFFSET)) hit = i;
        end
`else
        lo = 0;
`endif
        exp_ready = (q.size() != DEPTH) || (hit >= 0);
        compared++;
        if (resolve_ready_o !== exp_ready) begin
            mismatched++;
            $display("FAIL ready: got %b expected %b (queued %0d)", resolve_ready_o, exp_ready, q.size());
        end
        acc = v && exp_ready && !fl;
        mis = acc && (!pv || pt != tgt);
        if (fl) begin
            q.delete();
            exp_mis = 1'b0;
        end else begin
            exp_mis = mis;
            if (mis) exp_redir = tgt;
            if (mis && !dbg && hit >= 0) q[hit].target = tgt;
            if (q.size() != 0) void'(q.pop_front());
            if (mis && !dbg && hit < 0) q.push_back('{pc, tgt});
        end
        @(posedge clk_i);
        #2;
        compared++;
        if (mispredict_o !== exp_mis) begin
            mismatched++;
            $display("FAIL mispredict: got %b expected %b", mispredict_o, exp_mis);
        end
        compared++;
        if (redirect_pc_o !== exp_redir) begin
            mismatched++;
            $display("FAIL redirect_pc: got %h expected %h", redirect_pc_o, exp_redir);
        end
        compared++;
        if (fb_valid_o !== (q.size() != 0)) begin
            mismatched++;
            $display("FAIL fb_valid: got %b expected %b", fb_valid_o, q.size() != 0);
        end
        if (q.size() != 0) begin
            compared++;
            if (fb_branch_pc_o !== q[0].pc || fb_target_addr_o !== q[0].target) begin
                mismatched++;
                $display("FAIL fb_entry: got pc %h tgt %h expected pc %h tgt %h",
                         fb_branch_pc_o, fb_target_addr_o, q[0].pc, q[0].target);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        compared++;
        if (resolve_ready_o !== 1'b1 || mispredict_o !== 1'b0 || fb_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got ready %b mis %b fbv %b expected 1 0 0",
                     resolve_ready_o, mispredict_o, fb_valid_o);
        end
        compared++;
        if (redirect_pc_o !== 32'h0 || fb_branch_pc_o !== 32'h0 || fb_target_addr_o !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_data: got redir %h pc %h tgt %h expected zeros",
                     redirect_pc_o, fb_branch_pc_o, fb_target_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(10);
    endtask

    task automatic test_single_mispredict();
        cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h2000, 1'b0, 1'b0);
        compared++;
        if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h2000) begin
            mismatched++;
            $display("FAIL single_redirect: got %b %h expected 1 00002000", mispredict_o, redirect_pc_o);
        end
        compared++;
        if (fb_valid_o !== 1'b1 || fb_branch_pc_o !== 32'h1000 || fb_target_addr_o !== 32'h2000) begin
            mismatched++;
            $display("FAIL single_fb: got %b %h %h expected 1 00001000 00002000",
                     fb_valid_o, fb_branch_pc_o, fb_target_addr_o);
        end
        idle(1);
        compared++;
        if (fb_valid_o !== 1'b0 || mispredict_o !== 1'b0) begin
            mismatched++;
            $display("FAIL single_after: got fbv %b mis %b expected 0 0", fb_valid_o, mispredict_o);
        end
    endtask

    task automatic test_correct_prediction();
        cycle(1'b1, 32'h1000, 1'b1, 32'h2000, 32'h2000, 1'b0, 1'b0);
        compared++;
        if (mispredict_o !== 1'b0 || fb_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL correct_pred: got mis %b fbv %b expected 0 0", mispredict_o, fb_valid_o);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        addr_t tgt;
        for (int i = 0; i < 5; i++) begin
            tgt = 32'h8000 + 32'(i * 16);
            cycle(1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h4, tgt, 1'b0, 1'b0);
            compared++;
            if (mispredict_o !== 1'b1 || redirect_pc_o !== tgt ||
                fb_branch_pc_o !== 32'h100 + 32'(i * 4) || fb_target_addr_o !== tgt) begin
                mismatched++;
                $display("FAIL b2b_%0d: got mis %b redir %h fbpc %h fbtgt %h expected 1 %h %h %h",
                         i, mispredict_o, redirect_pc_o, fb_branch_pc_o, fb_target_addr_o,
                         tgt, 32'h100 + 32'(i * 4), tgt);
            end
        end
        idle(2);
    endtask

    task automatic test_debug_and_flush();
        cycle(1'b1, 32'h3000, 1'b0, 32'h0, 32'h3300, 1'b0, 1'b1);
        compared++;
        if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h3300 || fb_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL debug: got mis %b redir %h fbv %b expected 1 00003300 0",
                     mispredict_o, redirect_pc_o, fb_valid_o);
        end
        cycle(1'b1, 32'h3100, 1'b0, 32'h0, 32'h3400, 1'b0, 1'b0);
        cycle(1'b1, 32'h3200, 1'b0, 32'h0, 32'h3500, 1'b1, 1'b0);
        compared++;
        if (fb_valid_o !== 1'b0 || mispredict_o !== 1'b0 || redirect_pc_o !== 32'h3400) begin
            mismatched++;
            $display("FAIL flush: got fbv %b mis %b redir %h expected 0 0 00003400",
                     fb_valid_o, mispredict_o, redirect_pc_o);
        end
        idle(2);
    endtask

    task automatic test_random();
        addr_t pc;
        addr_t tgt;
        addr_t pt;
        for (int i = 0; i < 400; i++) begin
            pc  = 32'h200 + 32'($urandom_range(0, 7) * 2);
            tgt = 32'($urandom_range(0, 3)) << 8;
            pt  = ($urandom_range(0, 1) == 1) ? tgt : 32'($urandom_range(0, 3)) << 8;
            cycle($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1, pt, tgt,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_single_mispredict();
        test_correct_prediction();
        test_back_to_back();
        test_debug_and_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
